// File: rtl/score_keeper.sv
// score_keeper: two-requester BCD score accumulator (0000-9999) that saturates at 9999.
// Latency: grant edge, then 4 busy cycles (one digit per clock); requests are held off while busy.
`timescale 1ns/1ps
module score_keeper #(
   parameter bit PRIORITY_RR = 1'b1
) (
   input  logic       clk_100MHz,
   input  logic       reset_n,
   input  logic       req_a,
   input  logic [3:0] pts_a,
   input  logic       req_b,
   input  logic [3:0] pts_b,
   input  logic       clr,
   output logic       ack_a,
   output logic       ack_b,
   output logic       busy,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       sat
);

   typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       grant_a;
   logic       grant_b;
   logic       last_b;
   logic [3:0] pts_lat;
   logic [3:0] work [4];
   logic       carry;
   logic [1:0] idx;
   logic [3:0] addend;
   logic [4:0] sum;
   logic [3:0] digit_nxt;
   logic       carry_nxt;
   logic [3:0] pts_a_clamp;
   logic [3:0] pts_b_clamp;

   assign pts_a_clamp = (pts_a > 4'd9) ? 4'd9 : pts_a;
   assign pts_b_clamp = (pts_b > 4'd9) ? 4'd9 : pts_b;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               // last_b set means B won last time, so A is favoured on a tie
               if (req_a && (!req_b || !PRIORITY_RR || last_b)) grant_a = 1'b1;
               else if (req_b)                                     grant_b = 1'b1;
               if (grant_a || grant_b) state_nxt = ADD0;
            end
            ADD0:    state_nxt = ADD1;
            ADD1:    state_nxt = ADD2;
            ADD2:    state_nxt = ADD3;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      idx    = 2'd0;
      addend = 4'd0;
      case (state)
         ADD0: begin
            idx    = 2'd0;
            addend = pts_lat;
         end
         ADD1:    idx = 2'd1;
         ADD2:    idx = 2'd2;
         ADD3:    idx = 2'd3;
         default: idx = 2'd0;
      endcase
      sum       = {1'b0, work[idx]} + {1'b0, addend} + {4'd0, carry};
      carry_nxt = (sum > 5'd9);
      // sum is at most 19, so the low nibble minus 10 wraps to the right digit
      digit_nxt = carry_nxt ? (sum[3:0] - 4'd10) : sum[3:0];
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         ones      <= 4'd0;
         tens      <= 4'd0;
         hundreds  <= 4'd0;
         thousands <= 4'd0;
         sat       <= 1'b0;
         carry     <= 1'b0;
         last_b    <= 1'b1;
         pts_lat   <= 4'd0;
         work      <= '{default: 4'd0};
      end else begin
         ack_a <= grant_a;
         ack_b <= grant_b;
         if (clr) begin
            ones      <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            sat       <= 1'b0;
            carry     <= 1'b0;
         end else if (grant_a || grant_b) begin
            pts_lat <= grant_a ? pts_a_clamp : pts_b_clamp;
            work[0] <= ones;
            work[1] <= tens;
            work[2] <= hundreds;
            work[3] <= thousands;
            carry   <= 1'b0;
            last_b  <= grant_b;
         end else if (busy) begin
            work[idx] <= digit_nxt;
            carry     <= carry_nxt;
            if (state == ADD3) begin
               if (carry_nxt || sat) begin
                  ones      <= 4'd9;
                  tens      <= 4'd9;
                  hundreds  <= 4'd9;
                  thousands <= 4'd9;
                  sat       <= 1'b1;
               end else begin
                  ones      <= work[0];
                  tens      <= work[1];
                  hundreds  <= work[2];
                  thousands <= digit_nxt;
               end
            end
         end
      end
   end

endmodule
